minimac2_mdio: RTL and testbench

Hardware MII management (MDIO, IEEE 802.3 clause 22) master for the minimac2 Ethernet core. It replaces CPU bit-banging of the PHY management pins: software issues one register read or write, and the block generates the whole 64-bit frame on MDC/MDIO, then returns read data and status. It sits between the minimac2 CSR interface and the phy_mii_clk/phy_mii_data pads. The tristate buffer and the input synchronizer stay outside this block.

---
 rtl/minimac2_mdio.sv | 126 ++++++++++++
 tb/tb_minimac2_mdio.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/minimac2_mdio.sv
// MII management (clause 22) master: serializes one 64-bit MDIO frame per request
// and returns read data plus a no-PHY flag taken from the turnaround bit.
module minimac2_mdio #(
   parameter int unsigned clk_div = 10
) (
   input  logic        sys_clk,
   input  logic        sys_rst,
   input  logic        start,
   input  logic        op_read,
   input  logic [4:0]  phy_addr,
   input  logic [4:0]  reg_addr,
   input  logic [15:0] wdata,
   output logic [15:0] rdata,
   output logic        rd_err,
   output logic        busy,
   output logic        done,
   output logic        phy_mii_clk,
   output logic        mii_data_oe,
   output logic        mii_data_do,
   input  logic        mii_data_di
);

   // state  | meaning
   // IDLE   | MDC low, MDIO released, waiting for start
   // SHIFT  | frame in flight, one bit per 2*clk_div cycles
   // FINISH | single-cycle done pulse, read results committed
   typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

   localparam logic [7:0] HALF_LAST = 8'(clk_div - 1);

   state_t      state, state_nxt;
   logic [63:0] frame;
   logic [5:0]  bit_cnt;
   logic [7:0]  half_cnt;
   logic        phase;
   logic        is_read;
   logic [15:0] rx_sh;
   logic        err_sh;
   logic        half_end;
   logic        bit_end;
   logic        sample;

   assign half_end = (half_cnt == HALF_LAST);
   assign bit_end  = half_end & phase;
   // First cycle of the MDC high phase; TA bit 47 and the 16 data bits are captured here.
   assign sample   = (state == SHIFT) & phase & (half_cnt == 8'd0) & is_read & (bit_cnt >= 6'd47);

   always_comb begin
      state_nxt   = state;
      busy        = 1'b0;
      done        = 1'b0;
      phy_mii_clk = 1'b0;
      mii_data_oe = 1'b0;
      mii_data_do = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_nxt = SHIFT;
         end
         SHIFT: begin
            busy        = 1'b1;
            phy_mii_clk = phase;
            mii_data_oe = ~is_read | (bit_cnt < 6'd46);
            mii_data_do = mii_data_oe & frame[63];
            if (bit_end && bit_cnt == 6'd63) state_nxt = FINISH;
         end
         FINISH: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state    <= IDLE;
         frame    <= '0;
         bit_cnt  <= '0;
         half_cnt <= '0;
         phase    <= 1'b0;
         is_read  <= 1'b0;
         rx_sh    <= '0;
         err_sh   <= 1'b0;
         rdata    <= '0;
         rd_err   <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (start) begin
                  frame    <= {32'hFFFF_FFFF, 2'b01, (op_read ? 2'b10 : 2'b01), phy_addr, reg_addr,
                               (op_read ? 2'b11 : 2'b10), (op_read ? 16'hFFFF : wdata)};
                  is_read  <= op_read;
                  bit_cnt  <= '0;
                  half_cnt <= '0;
                  phase    <= 1'b0;
               end
            end
            SHIFT: begin
               if (half_end) begin
                  half_cnt <= '0;
                  phase    <= ~phase;
                  if (phase) begin
                     bit_cnt <= bit_cnt + 6'd1;
                     frame   <= {frame[62:0], 1'b0};
                  end
               end else begin
                  half_cnt <= half_cnt + 8'd1;
               end
               if (sample) begin
                  if (bit_cnt == 6'd47) err_sh <= mii_data_di;
                  else                  rx_sh  <= {rx_sh[14:0], mii_data_di};
               end
            end
            FINISH: begin
               if (is_read) begin
                  rdata  <= rx_sh;
                  rd_err <= err_sh;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_minimac2_mdio.sv
// Directed bench for minimac2_mdio: two instances (clk_div=4 and clk_div=1) share
// command inputs; sel picks which one a frame is driven into and observed from.
module tb_minimac2_mdio;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        op_read;
   logic [4:0]  phy_addr;
   logic [4:0]  reg_addr;
   logic [15:0] wdata;
   logic        di_drv;
   logic        sel;

   logic        start4, start1, di4, di1;
   logic [15:0] rdata4, rdata1;
   logic        rd_err4, rd_err1, busy4, busy1, done4, done1;
   logic        mdc4, mdc1, oe4, oe1, do4, do1;

   logic [15:0] rdata_o;
   logic        rd_err_o, busy_o, done_o, mdc_o, oe_o, do_o;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign start4   = start & ~sel;
   assign start1   = start & sel;
   assign di4      = sel ? 1'b1 : di_drv;
   assign di1      = sel ? di_drv : 1'b1;
   assign rdata_o  = sel ? rdata1  : rdata4;
   assign rd_err_o = sel ? rd_err1 : rd_err4;
   assign busy_o   = sel ? busy1   : busy4;
   assign done_o   = sel ? done1   : done4;
   assign mdc_o    = sel ? mdc1    : mdc4;
   assign oe_o     = sel ? oe1     : oe4;
   assign do_o     = sel ? do1     : do4;

   minimac2_mdio #(.clk_div(4)) u_div4 (
      .sys_clk(clk), .sys_rst(rst), .start(start4), .op_read(op_read),
      .phy_addr(phy_addr), .reg_addr(reg_addr), .wdata(wdata),
      .rdata(rdata4), .rd_err(rd_err4), .busy(busy4), .done(done4),
      .phy_mii_clk(mdc4), .mii_data_oe(oe4), .mii_data_do(do4), .mii_data_di(di4));

   minimac2_mdio #(.clk_div(1)) u_div1 (
      .sys_clk(clk), .sys_rst(rst), .start(start1), .op_read(op_read),
      .phy_addr(phy_addr), .reg_addr(reg_addr), .wdata(wdata),
      .rdata(rdata1), .rd_err(rd_err1), .busy(busy1), .done(done1),
      .phy_mii_clk(mdc1), .mii_data_oe(oe1), .mii_data_do(do1), .mii_data_di(di1));

   // Drives one frame and records what the pins did. Observation k is taken #1 after
   // the k-th edge following the start cycle T, i.e. it reflects cycle T+k.
   task automatic run_frame(input bit rd, input logic [4:0] pa, input logic [4:0] ra,
                            input logic [15:0] wd, input logic [15:0] rsp, input logic ta,
                            input bit nophy, input bit extra,
                            output logic [63:0] samp, output logic [63:0] oe_bits,
                            output int done_k, output int done_n, output int rises,
                            output logic [15:0] rdata_pre, output logic busy_after);
      int   cd, n, b, ph;
      logic prev_mdc;
      cd = sel ? 1 : 4;
      n  = 128 * cd + 3;
      @(posedge clk); #1;
      op_read = rd; phy_addr = pa; reg_addr = ra; wdata = wd; di_drv = 1'b1; start = 1'b1;
      samp = '0; oe_bits = '0; done_k = -1; done_n = 0; rises = 0; prev_mdc = 1'b0;
      rdata_pre = '0; busy_after = 1'b0;
      for (int k = 1; k <= n; k++) begin
         @(posedge clk); #1;
         start = 1'b0;
         b  = (k - 1) / (2 * cd);
         ph = (k - 1) % (2 * cd);
         if (extra && (k == 5 * cd || k == 128 * cd + 1)) start = 1'b1;
         if (ph == 0 && b < 64) begin
            if (!rd || nophy || b < 47) di_drv = 1'b1;
            else if (b == 47)           di_drv = ta;
            else                        di_drv = rsp[63 - b];
            oe_bits[63 - b] = oe_o;
         end
         if (mdc_o && !prev_mdc) begin
            if (rises < 64) samp[63 - rises] = do_o;
            rises++;
         end
         prev_mdc = mdc_o;
         if (done_o) begin
            done_n++;
            done_k = k;
         end
         if (k == 128 * cd) rdata_pre = rdata_o;
         if (k == n) busy_after = busy_o;
      end
      start = 1'b0;
      di_drv = 1'b1;
   endtask

   task automatic test_reset();
      sel = 1'b0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (rdata_o !== 16'h0000) begin errors++; $display("FAIL reset_rdata got %h want 0000", rdata_o); end
      checks++; if (rd_err_o !== 1'b0) begin errors++; $display("FAIL reset_rd_err got %b want 0", rd_err_o); end
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy_o); end
      checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done_o); end
      checks++; if ({mdc_o, oe_o, do_o} !== 3'b000) begin errors++; $display("FAIL reset_pins got %b want 000", {mdc_o, oe_o, do_o}); end
      rst = 1'b0;
   endtask

   task automatic test_write();
      logic [63:0] samp, oe_bits, exp;
      int          dk, dn, rises;
      logic [15:0] pre;
      logic        ba;
      sel = 1'b0;
      exp = {32'hFFFF_FFFF, 2'b01, 2'b01, 5'h01, 5'h00, 2'b10, 16'h8000};
      run_frame(1'b0, 5'h01, 5'h00, 16'h8000, 16'h0, 1'b0, 1'b0, 1'b0, samp, oe_bits, dk, dn, rises, pre, ba);
      checks++; if (rises !== 64) begin errors++; $display("FAIL write_mdc_rises got %0d want 64", rises); end
      checks++; if (samp !== exp) begin errors++; $display("FAIL write_bits got %h want %h", samp, exp); end
      checks++; if (oe_bits !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL write_oe got %h want all ones", oe_bits); end
      checks++; if (dk !== 513) begin errors++; $display("FAIL write_done_cycle got %0d want 513", dk); end
      checks++; if (dn !== 1) begin errors++; $display("FAIL write_done_count got %0d want 1", dn); end
      checks++; if (rdata_o !== 16'h0000) begin errors++; $display("FAIL write_rdata got %h want 0000", rdata_o); end
   endtask

   task automatic test_read_phy();
      logic [63:0] samp, oe_bits;
      int          dk, dn, rises;
      logic [15:0] pre;
      logic        ba;
      logic [45:0] exp_hdr;
      sel = 1'b0;
      exp_hdr = {32'hFFFF_FFFF, 2'b01, 2'b10, 5'h1F, 5'h02};
      run_frame(1'b1, 5'h1F, 5'h02, 16'h0, 16'h796D, 1'b0, 1'b0, 1'b0, samp, oe_bits, dk, dn, rises, pre, ba);
      checks++; if (oe_bits !== 64'hFFFF_FFFF_FFFC_0000) begin errors++; $display("FAIL read_oe got %h want ffffffff fffc0000", oe_bits); end
      checks++; if (samp[63:18] !== exp_hdr) begin errors++; $display("FAIL read_header got %h want %h", samp[63:18], exp_hdr); end
      checks++; if (pre !== 16'h0000) begin errors++; $display("FAIL read_rdata_early got %h want 0000", pre); end
      checks++; if (dk !== 513) begin errors++; $display("FAIL read_done_cycle got %0d want 513", dk); end
      checks++; if (rdata_o !== 16'h796D) begin errors++; $display("FAIL read_rdata got %h want 796d", rdata_o); end
      checks++; if (rd_err_o !== 1'b0) begin errors++; $display("FAIL read_rd_err got %b want 0", rd_err_o); end
   endtask

   task automatic test_read_nophy();
      logic [63:0] samp, oe_bits;
      int          dk, dn, rises;
      logic [15:0] pre;
      logic        ba;
      sel = 1'b0;
      run_frame(1'b1, 5'h07, 5'h01, 16'h0, 16'h0, 1'b1, 1'b1, 1'b0, samp, oe_bits, dk, dn, rises, pre, ba);
      checks++; if (rdata_o !== 16'hFFFF) begin errors++; $display("FAIL nophy_rdata got %h want ffff", rdata_o); end
      checks++; if (rd_err_o !== 1'b1) begin errors++; $display("FAIL nophy_rd_err got %b want 1", rd_err_o); end
      run_frame(1'b0, 5'h03, 5'h04, 16'h1234, 16'h0, 1'b0, 1'b0, 1'b0, samp, oe_bits, dk, dn, rises, pre, ba);
      checks++; if (dk !== 513) begin errors++; $display("FAIL nophy_write_done got %0d want 513", dk); end
      checks++; if (rdata_o !== 16'hFFFF) begin errors++; $display("FAIL nophy_write_rdata got %h want ffff", rdata_o); end
      checks++; if (rd_err_o !== 1'b1) begin errors++; $display("FAIL nophy_write_rd_err got %b want 1", rd_err_o); end
   endtask

   task automatic test_back_to_back();
      logic [63:0] samp, oe_bits, exp;
      int          dk, dn, rises;
      logic [15:0] pre;
      logic        ba;
      sel = 1'b0;
      exp = {32'hFFFF_FFFF, 2'b01, 2'b01, 5'h05, 5'h1A, 2'b10, 16'hA5C3};
      run_frame(1'b0, 5'h05, 5'h1A, 16'hA5C3, 16'h0, 1'b0, 1'b0, 1'b1, samp, oe_bits, dk, dn, rises, pre, ba);
      checks++; if (dn !== 1) begin errors++; $display("FAIL b2b_done_count got %0d want 1", dn); end
      checks++; if (dk !== 513) begin errors++; $display("FAIL b2b_done_cycle got %0d want 513", dk); end
      checks++; if (samp !== exp) begin errors++; $display("FAIL b2b_bits got %h want %h", samp, exp); end
      checks++; if (ba !== 1'b0) begin errors++; $display("FAIL b2b_busy_after got %b want 0", ba); end
   endtask

   task automatic test_reset_mid();
      logic [63:0] samp, oe_bits;
      int          dk, dn, rises, dones;
      logic [15:0] pre;
      logic        ba;
      sel = 1'b0;
      @(posedge clk); #1;
      op_read = 1'b1; phy_addr = 5'h1F; reg_addr = 5'h02; di_drv = 1'b1; start = 1'b1;
      for (int k = 1; k <= 321; k++) begin
         @(posedge clk); #1;
         start = 1'b0;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checks++; if ({mdc_o, oe_o, busy_o, done_o} !== 4'b0000) begin errors++; $display("FAIL midrst_pins got mdc/oe/busy/done=%b want 0000", {mdc_o, oe_o, busy_o, done_o}); end
      checks++; if (rdata_o !== 16'h0000) begin errors++; $display("FAIL midrst_rdata got %h want 0000", rdata_o); end
      dones = 0;
      for (int k = 0; k < 600; k++) begin
         @(posedge clk); #1;
         if (done_o) dones++;
      end
      checks++; if (dones !== 0) begin errors++; $display("FAIL midrst_no_done got %0d want 0", dones); end
      run_frame(1'b1, 5'h1F, 5'h02, 16'h0, 16'h1357, 1'b0, 1'b0, 1'b0, samp, oe_bits, dk, dn, rises, pre, ba);
      checks++; if (dk !== 513) begin errors++; $display("FAIL midrst_read_done got %0d want 513", dk); end
      checks++; if (rdata_o !== 16'h1357) begin errors++; $display("FAIL midrst_read_rdata got %h want 1357", rdata_o); end
   endtask

   task automatic test_clkdiv1();
      logic [63:0] samp, oe_bits;
      int          dk, dn, rises;
      logic [15:0] pre;
      logic        ba;
      sel = 1'b1;
      run_frame(1'b1, 5'h02, 5'h11, 16'h0, 16'h3C5A, 1'b0, 1'b0, 1'b0, samp, oe_bits, dk, dn, rises, pre, ba);
      checks++; if (dk !== 129) begin errors++; $display("FAIL div1_done_cycle got %0d want 129", dk); end
      checks++; if (rises !== 64) begin errors++; $display("FAIL div1_mdc_rises got %0d want 64", rises); end
      checks++; if (rdata_o !== 16'h3C5A) begin errors++; $display("FAIL div1_rdata got %h want 3c5a", rdata_o); end
      checks++; if (rd_err_o !== 1'b0) begin errors++; $display("FAIL div1_rd_err got %b want 0", rd_err_o); end
      sel = 1'b0;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; op_read = 1'b0; phy_addr = '0; reg_addr = '0;
      wdata = '0; di_drv = 1'b1; sel = 1'b0;
      test_reset();
      test_write();
      test_read_phy();
      test_read_nophy();
      test_back_to_back();
      test_reset_mid();
      test_clkdiv1();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
